// File: rtl/wheel_pkg.sv
// Shared definitions for the multi-wheel node integrator.
// Holds the datapath widths, the run-control state enum and the per-node state record.
package wheel_pkg;

    localparam int unsigned POSITION_SIZE = 8;
    localparam int unsigned VELOCITY_SIZE = 6;
    localparam int unsigned FORCE_SIZE    = 8;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } wheel_state_e;

    typedef struct packed {
        logic signed [POSITION_SIZE-1:0] px;
        logic signed [POSITION_SIZE-1:0] py;
        logic signed [VELOCITY_SIZE-1:0] vx;
        logic signed [VELOCITY_SIZE-1:0] vy;
    } node_state_t;

endpackage

// File: rtl/node_step_calc.sv
// One-axis semi-implicit Euler step: accelerate, damp, saturate velocity, then move and
// saturate position with the new velocity. Purely combinational.
// Ports:
//   pos, vel, frc   current position, velocity and net force on this axis
//   pos_next        saturated updated position
//   vel_next        saturated updated velocity
//   sat             either result was clamped
module node_step_calc #(
    parameter int unsigned POS_W      = 8,
    parameter int unsigned VEL_W      = 6,
    parameter int unsigned FRC_W      = 8,
    parameter int          DT         = 1,
    parameter int          ACCEL_BIAS = 0,
    parameter int unsigned MASS_SHIFT = 0,
    parameter int unsigned DAMP_SHIFT = 3
) (
    input  logic signed [POS_W-1:0] pos,
    input  logic signed [VEL_W-1:0] vel,
    input  logic signed [FRC_W-1:0] frc,
    output logic signed [POS_W-1:0] pos_next,
    output logic signed [VEL_W-1:0] vel_next,
    output logic                    sat
);

    // Wide enough that nothing wraps before the clamps.
    localparam int unsigned W = VEL_W + FRC_W + 4;
    localparam int VEL_MAX = (1 << (VEL_W - 1)) - 1;
    localparam int VEL_MIN = -(1 << (VEL_W - 1));
    localparam int POS_MAX = (1 << (POS_W - 1)) - 1;
    localparam int POS_MIN = -(1 << (POS_W - 1));

    localparam logic signed [W-1:0] DT_W      = W'(DT);
    localparam logic signed [W-1:0] BIAS_W    = W'(ACCEL_BIAS);
    localparam logic signed [W-1:0] VEL_MAX_W = W'(VEL_MAX);
    localparam logic signed [W-1:0] VEL_MIN_W = W'(VEL_MIN);
    localparam logic signed [W-1:0] POS_MAX_W = W'(POS_MAX);
    localparam logic signed [W-1:0] POS_MIN_W = W'(POS_MIN);

    logic signed [W-1:0] frc_w, vel_w, pos_w, accel, v1, v2, vel_sat_w, pos_sum;
    logic                sat_v, sat_p;

    always_comb begin
        frc_w = W'(frc);
        vel_w = W'(vel);
        pos_w = W'(pos);
        accel = (frc_w >>> MASS_SHIFT) + BIAS_W;
        v1    = vel_w + accel * DT_W;
        if (DAMP_SHIFT != 0) begin
            v2 = v1 - (v1 >>> DAMP_SHIFT);
        end else begin
            v2 = v1;
        end

        sat_v = 1'b0;
        if (v2 > VEL_MAX_W) begin
            vel_next = VEL_W'(VEL_MAX);
            sat_v    = 1'b1;
        end else if (v2 < VEL_MIN_W) begin
            vel_next = VEL_W'(VEL_MIN);
            sat_v    = 1'b1;
        end else begin
            vel_next = v2[VEL_W-1:0];
        end

        // Position advances with the already-clamped velocity.
        vel_sat_w = W'(vel_next);
        pos_sum   = pos_w + vel_sat_w * DT_W;
        sat_p     = 1'b0;
        if (pos_sum > POS_MAX_W) begin
            pos_next = POS_W'(POS_MAX);
            sat_p    = 1'b1;
        end else if (pos_sum < POS_MIN_W) begin
            pos_next = POS_W'(POS_MIN);
            sat_p    = 1'b1;
        end else begin
            pos_next = pos_sum[POS_W-1:0];
        end

        sat = sat_v | sat_p;
    end

endmodule

// File: rtl/wheel_node_integrator.sv
// Multi-wheel soft-body node integrator. Holds position/velocity for NUM_WHEELS x NUM_NODES
// nodes, integrates one wheel per run from a per-node force stream, and streams each updated
// node downstream over valid/ready.
// Ports:
//   clk_in, rst_n_in                   clock, async active-low reset
//   begin_in, wheel_in                 start a run on a wheel (honoured in idle only)
//   load_*                             idle-time write of one node's initial state
//   force_valid_in/force_ready_out     force stream handshake, force_x_in/force_y_in payload
//   node_out_*/velocity_out_*          updated node stream, node_out_ready_in backpressure
//   busy_out, sat_out, result_out      run active, sticky saturation, completion pulse
module wheel_node_integrator
    import wheel_pkg::*;
#(
    parameter int unsigned NUM_WHEELS = 2,
    parameter int unsigned NUM_NODES  = 4,
    parameter int          DT         = 1,
    parameter int          GRAVITY    = -1,
    parameter int unsigned MASS_SHIFT = 0,
    parameter int unsigned DAMP_SHIFT = 3,
    localparam int unsigned WB = (NUM_WHEELS > 1) ? $clog2(NUM_WHEELS) : 1,
    localparam int unsigned NB = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
    input  logic                            clk_in,
    input  logic                            rst_n_in,
    input  logic                            begin_in,
    input  logic [WB-1:0]                   wheel_in,
    input  logic                            load_valid_in,
    input  logic [WB-1:0]                   load_wheel_in,
    input  logic [NB-1:0]                   load_node_in,
    input  logic signed [POSITION_SIZE-1:0] load_px_in,
    input  logic signed [POSITION_SIZE-1:0] load_py_in,
    input  logic signed [VELOCITY_SIZE-1:0] load_vx_in,
    input  logic signed [VELOCITY_SIZE-1:0] load_vy_in,
    input  logic                            force_valid_in,
    output logic                            force_ready_out,
    input  logic signed [FORCE_SIZE-1:0]    force_x_in,
    input  logic signed [FORCE_SIZE-1:0]    force_y_in,
    output logic                            node_out_valid,
    input  logic                            node_out_ready_in,
    output logic [NB-1:0]                   node_out_idx,
    output logic signed [POSITION_SIZE-1:0] node_out_x,
    output logic signed [POSITION_SIZE-1:0] node_out_y,
    output logic signed [VELOCITY_SIZE-1:0] velocity_out_x,
    output logic signed [VELOCITY_SIZE-1:0] velocity_out_y,
    output logic                            busy_out,
    output logic                            sat_out,
    output logic                            result_out
);

    wheel_state_e  state_q, state_d;
    logic [WB-1:0] wheel_q;
    logic [NB-1:0] node_q;
    node_state_t   mem_q [NUM_WHEELS][NUM_NODES];

    // Pre-load copy of a node written in the same cycle the run was started.
    logic          byp_valid_q;
    logic [NB-1:0] byp_node_q;
    node_state_t   byp_q;

    logic          out_valid_q;
    logic [NB-1:0] out_idx_q;
    node_state_t   out_q;
    logic          sat_q;

    node_state_t cur, nxt;
    logic        sat_x, sat_y;
    logic        begin_ok, load_ok, force_acc, out_acc, last_node;

    assign begin_ok  = begin_in && (state_q == StIdle) && (int'(wheel_in) < int'(NUM_WHEELS));
    assign load_ok   = load_valid_in && (state_q == StIdle)
                       && (int'(load_wheel_in) < int'(NUM_WHEELS))
                       && (int'(load_node_in) < int'(NUM_NODES));
    assign force_acc = force_valid_in && force_ready_out;
    assign out_acc   = out_valid_q && node_out_ready_in;
    assign last_node = (node_q == NB'(NUM_NODES - 1));

    always_comb begin
        state_d         = state_q;
        force_ready_out = 1'b0;
        busy_out        = 1'b1;
        result_out      = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy_out = 1'b0;
                if (begin_ok) state_d = StRun;
            end
            StRun: begin
                force_ready_out = !out_valid_q || node_out_ready_in;
                if (force_acc && last_node) state_d = StDrain;
            end
            StDrain: begin
                if (out_acc) state_d = StDone;
            end
            StDone: begin
                result_out = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cur = mem_q[wheel_q][node_q];
        if (byp_valid_q && (byp_node_q == node_q)) cur = byp_q;
    end

    node_step_calc #(
        .POS_W      (POSITION_SIZE),
        .VEL_W      (VELOCITY_SIZE),
        .FRC_W      (FORCE_SIZE),
        .DT         (DT),
        .ACCEL_BIAS (0),
        .MASS_SHIFT (MASS_SHIFT),
        .DAMP_SHIFT (DAMP_SHIFT)
    ) u_step_x (
        .pos      (cur.px),
        .vel      (cur.vx),
        .frc      (force_x_in),
        .pos_next (nxt.px),
        .vel_next (nxt.vx),
        .sat      (sat_x)
    );

    node_step_calc #(
        .POS_W      (POSITION_SIZE),
        .VEL_W      (VELOCITY_SIZE),
        .FRC_W      (FORCE_SIZE),
        .DT         (DT),
        .ACCEL_BIAS (GRAVITY),
        .MASS_SHIFT (MASS_SHIFT),
        .DAMP_SHIFT (DAMP_SHIFT)
    ) u_step_y (
        .pos      (cur.py),
        .vel      (cur.vy),
        .frc      (force_y_in),
        .pos_next (nxt.py),
        .vel_next (nxt.vy),
        .sat      (sat_y)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= StIdle;
            wheel_q     <= '0;
            node_q      <= '0;
            mem_q       <= '{default: '0};
            byp_valid_q <= 1'b0;
            byp_node_q  <= '0;
            byp_q       <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_q       <= '0;
            sat_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (begin_ok) begin
                wheel_q     <= wheel_in;
                node_q      <= '0;
                sat_q       <= 1'b0;
                byp_valid_q <= load_ok && (load_wheel_in == wheel_in);
                byp_node_q  <= load_node_in;
                byp_q       <= mem_q[load_wheel_in][load_node_in];
            end
            if (load_ok) begin
                mem_q[load_wheel_in][load_node_in] <= '{px: load_px_in, py: load_py_in,
                                                         vx: load_vx_in, vy: load_vy_in};
            end
            if (force_acc) begin
                mem_q[wheel_q][node_q] <= nxt;
                out_q                  <= nxt;
                out_idx_q              <= node_q;
                out_valid_q            <= 1'b1;
                node_q                 <= node_q + 1'b1;
                sat_q                  <= sat_q | sat_x | sat_y;
            end else if (out_acc) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign node_out_valid = out_valid_q;
    assign node_out_idx   = out_idx_q;
    assign node_out_x     = out_q.px;
    assign node_out_y     = out_q.py;
    assign velocity_out_x = out_q.vx;
    assign velocity_out_y = out_q.vy;
    assign sat_out        = sat_q;

endmodule

// File: tb/tb_wheel_node_integrator.sv
// Bench for wheel_node_integrator: two instances (no damping, default damping) share the
// same stimulus and are checked against an arithmetic model of the node update rules.
module tb_wheel_node_integrator;
    import wheel_pkg::*;

    localparam int NW = 2;
    localparam int NN = 4;
    localparam int unsigned WB = 1;
    localparam int unsigned NB = 2;
    localparam int GRAV = -1;
    localparam int TDT = 1;
    localparam int MSHIFT = 0;
    localparam int PMAX = (1 << (POSITION_SIZE - 1)) - 1;
    localparam int PMIN = -(1 << (POSITION_SIZE - 1));
    localparam int VMAX = (1 << (VELOCITY_SIZE - 1)) - 1;
    localparam int VMIN = -(1 << (VELOCITY_SIZE - 1));

    logic clk_in = 1'b0;
    logic rst_n_in;
    logic begin_in, load_valid_in, force_valid_in, node_out_ready_in;
    logic [WB-1:0] wheel_in, load_wheel_in;
    logic [NB-1:0] load_node_in;
    logic signed [POSITION_SIZE-1:0] load_px_in, load_py_in;
    logic signed [VELOCITY_SIZE-1:0] load_vx_in, load_vy_in;
    logic signed [FORCE_SIZE-1:0] force_x_in, force_y_in;

    logic fready [2], ovalid [2], busy [2], sat [2], res [2];
    logic [NB-1:0] nidx [2];
    logic signed [POSITION_SIZE-1:0] nx [2], ny [2];
    logic signed [VELOCITY_SIZE-1:0] vx [2], vy [2];

    always #5 clk_in = ~clk_in;

    wheel_node_integrator #(.DAMP_SHIFT(0)) dut_a (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .begin_in(begin_in), .wheel_in(wheel_in),
        .load_valid_in(load_valid_in), .load_wheel_in(load_wheel_in),
        .load_node_in(load_node_in), .load_px_in(load_px_in), .load_py_in(load_py_in),
        .load_vx_in(load_vx_in), .load_vy_in(load_vy_in), .force_valid_in(force_valid_in),
        .force_ready_out(fready[0]), .force_x_in(force_x_in), .force_y_in(force_y_in),
        .node_out_valid(ovalid[0]), .node_out_ready_in(node_out_ready_in),
        .node_out_idx(nidx[0]), .node_out_x(nx[0]), .node_out_y(ny[0]),
        .velocity_out_x(vx[0]), .velocity_out_y(vy[0]), .busy_out(busy[0]),
        .sat_out(sat[0]), .result_out(res[0])
    );

    wheel_node_integrator #(.DAMP_SHIFT(3)) dut_b (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .begin_in(begin_in), .wheel_in(wheel_in),
        .load_valid_in(load_valid_in), .load_wheel_in(load_wheel_in),
        .load_node_in(load_node_in), .load_px_in(load_px_in), .load_py_in(load_py_in),
        .load_vx_in(load_vx_in), .load_vy_in(load_vy_in), .force_valid_in(force_valid_in),
        .force_ready_out(fready[1]), .force_x_in(force_x_in), .force_y_in(force_y_in),
        .node_out_valid(ovalid[1]), .node_out_ready_in(node_out_ready_in),
        .node_out_idx(nidx[1]), .node_out_x(nx[1]), .node_out_y(ny[1]),
        .velocity_out_x(vx[1]), .velocity_out_y(vy[1]), .busy_out(busy[1]),
        .sat_out(sat[1]), .result_out(res[1])
    );

    int checks = 0;
    int errors = 0;

    // Model: [dut][wheel][node]
    int m_px [2][NW][NN], m_py [2][NW][NN], m_vx [2][NW][NN], m_vy [2][NW][NN];
    int e_px [2][NN], e_py [2][NN], e_vx [2][NN], e_vy [2][NN];
    bit e_sat [2];
    int f_x [NN], f_y [NN];
    int o_px0, o_py0, o_vx0, o_vy0;

    function automatic int damp_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic int clamp(input int x, input int lo, input int hi, inout bit s);
        if (x > hi) begin s = 1'b1; return hi; end
        if (x < lo) begin s = 1'b1; return lo; end
        return x;
    endfunction

    task automatic step(input int p, input int v, input int f, input int g, input int damp,
                        output int pn, output int vn, inout bit s);
        int a, v1, v2;
        a  = (f >>> MSHIFT) + g;
        v1 = v + a * TDT;
        v2 = (damp == 0) ? v1 : v1 - (v1 >>> damp);
        vn = clamp(v2, VMIN, VMAX, s);
        pn = clamp(p + vn * TDT, PMIN, PMAX, s);
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_d%0d_valid", tag, d), ovalid[d], 0);
            chk($sformatf("%s_d%0d_fready", tag, d), fready[d], 0);
            chk($sformatf("%s_d%0d_busy", tag, d), busy[d], 0);
            chk($sformatf("%s_d%0d_sat", tag, d), sat[d], 0);
            chk($sformatf("%s_d%0d_result", tag, d), res[d], 0);
            chk($sformatf("%s_d%0d_xy", tag, d), {nidx[d], nx[d], ny[d], vx[d], vy[d]}, 0);
        end
    endtask

    function automatic int rnd(input int lo, input int hi);
        return lo + int'($urandom_range(0, 32'(hi - lo)));
    endfunction

    task automatic do_load(input int w, input int n, input int px, input int py,
                           input int vxl, input int vyl);
        @(negedge clk_in);
        load_valid_in = 1'b1;
        load_wheel_in = WB'(w);
        load_node_in  = NB'(n);
        load_px_in    = POSITION_SIZE'(px);
        load_py_in    = POSITION_SIZE'(py);
        load_vx_in    = VELOCITY_SIZE'(vxl);
        load_vy_in    = VELOCITY_SIZE'(vyl);
        for (int d = 0; d < 2; d++) begin
            m_px[d][w][n] = px; m_py[d][w][n] = py; m_vx[d][w][n] = vxl; m_vy[d][w][n] = vyl;
        end
        @(negedge clk_in);
        load_valid_in = 1'b0;
    endtask

    task automatic rand_forces();
        for (int n = 0; n < NN; n++) begin
            f_x[n] = rnd(-128, 127);
            f_y[n] = rnd(-128, 127);
        end
    endtask

    task automatic zero_forces();
        for (int n = 0; n < NN; n++) begin
            f_x[n] = 0;
            f_y[n] = 0;
        end
    endtask

    // mode 0: always ready; 1: random ready and force gaps; 2: ready low for 5 cycles
    task automatic do_run(input int w, input int mode, input bit coload, input bit inject);
        int  s_px [2][NN], s_py [2][NN], s_vx [2][NN], s_vy [2][NN];
        int  nf, no, cyc, k;
        bit  finished, done_next, rdy, fv, ev, efr, last;
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < NN; n++) begin
                s_px[d][n] = m_px[d][w][n]; s_py[d][n] = m_py[d][w][n];
                s_vx[d][n] = m_vx[d][w][n]; s_vy[d][n] = m_vy[d][w][n];
            end
        end
        @(negedge clk_in);
        begin_in = 1'b1;
        wheel_in = WB'(w);
        if (coload) begin
            k = rnd(0, NN - 1);
            load_valid_in = 1'b1;
            load_wheel_in = WB'(w);
            load_node_in  = NB'(k);
            load_px_in    = POSITION_SIZE'(rnd(PMIN, PMAX));
            load_py_in    = POSITION_SIZE'(rnd(PMIN, PMAX));
            load_vx_in    = VELOCITY_SIZE'(rnd(VMIN, VMAX));
            load_vy_in    = VELOCITY_SIZE'(rnd(VMIN, VMAX));
            for (int d = 0; d < 2; d++) begin
                m_px[d][w][k] = int'(load_px_in); m_py[d][w][k] = int'(load_py_in);
                m_vx[d][w][k] = int'(load_vx_in); m_vy[d][w][k] = int'(load_vy_in);
            end
        end
        for (int d = 0; d < 2; d++) begin
            e_sat[d] = 1'b0;
            for (int n = 0; n < NN; n++) begin
                step(s_px[d][n], s_vx[d][n], f_x[n], 0, damp_of(d),
                     e_px[d][n], e_vx[d][n], e_sat[d]);
                step(s_py[d][n], s_vy[d][n], f_y[n], GRAV, damp_of(d),
                     e_py[d][n], e_vy[d][n], e_sat[d]);
            end
        end
        @(negedge clk_in);
        begin_in = 1'b0;
        load_valid_in = 1'b0;

        finished = 1'b0; done_next = 1'b0; nf = 0; no = 0; cyc = 0;
        while (!finished && cyc < 400) begin
            if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
            else if (mode == 2) rdy = !(cyc >= 2 && cyc < 7);
            else rdy = 1'b1;
            node_out_ready_in = rdy;
            fv = (nf < NN) && (mode != 1 || $urandom_range(0, 4) != 0);
            force_valid_in = fv;
            if (nf < NN) begin
                force_x_in = FORCE_SIZE'(f_x[nf]);
                force_y_in = FORCE_SIZE'(f_y[nf]);
            end
            if (inject && cyc == 1) begin
                begin_in      = 1'b1;
                wheel_in      = WB'(1 - w);
                load_valid_in = 1'b1;
                load_wheel_in = WB'(w);
                load_node_in  = '0;
                load_px_in    = POSITION_SIZE'(55);
                load_py_in    = POSITION_SIZE'(-44);
                load_vx_in    = VELOCITY_SIZE'(7);
                load_vy_in    = VELOCITY_SIZE'(-9);
            end else begin
                begin_in      = 1'b0;
                load_valid_in = 1'b0;
            end
            #1;
            ev  = (nf > no);
            efr = (nf < NN) && (!ev || rdy);
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("d%0d_valid_c%0d", d, cyc), ovalid[d], ev);
                chk($sformatf("d%0d_fready_c%0d", d, cyc), fready[d], efr);
                chk($sformatf("d%0d_result_c%0d", d, cyc), res[d], done_next);
                chk($sformatf("d%0d_busy_c%0d", d, cyc), busy[d], 1);
                if (ev) begin
                    chk($sformatf("d%0d_idx_n%0d", d, no), nidx[d], no);
                    chk($sformatf("d%0d_px_n%0d", d, no), nx[d], e_px[d][no]);
                    chk($sformatf("d%0d_py_n%0d", d, no), ny[d], e_py[d][no]);
                    chk($sformatf("d%0d_vx_n%0d", d, no), vx[d], e_vx[d][no]);
                    chk($sformatf("d%0d_vy_n%0d", d, no), vy[d], e_vy[d][no]);
                end
                if (done_next) chk($sformatf("d%0d_sat", d), sat[d], e_sat[d]);
            end
            if (ev && rdy && no == 0) begin
                o_px0 = int'(nx[0]); o_py0 = int'(ny[0]);
                o_vx0 = int'(vx[0]); o_vy0 = int'(vy[0]);
            end
            if (done_next) finished = 1'b1;
            last = ev && rdy && (no == NN - 1);
            if (ev && rdy) no++;
            if (fv && efr) nf++;
            done_next = last;
            @(negedge clk_in);
            cyc++;
        end
        force_valid_in = 1'b0;
        begin_in       = 1'b0;
        load_valid_in  = 1'b0;
        chk("run_completed", finished, 1);
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < NN; n++) begin
                m_px[d][w][n] = e_px[d][n]; m_py[d][w][n] = e_py[d][n];
                m_vx[d][w][n] = e_vx[d][n]; m_vy[d][w][n] = e_vy[d][n];
            end
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_result_after", d), res[d], 0);
            chk($sformatf("d%0d_busy_after", d), busy[d], 0);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < NW; w++)
                for (int n = 0; n < NN; n++) begin
                    m_px[d][w][n] = 0; m_py[d][w][n] = 0; m_vx[d][w][n] = 0; m_vy[d][w][n] = 0;
                end
    endtask

    initial begin
        begin_in = 0; wheel_in = '0; load_valid_in = 0; load_wheel_in = '0; load_node_in = '0;
        load_px_in = '0; load_py_in = '0; load_vx_in = '0; load_vy_in = '0;
        force_valid_in = 0; force_x_in = '0; force_y_in = '0; node_out_ready_in = 1;
        rst_n_in = 1'b0;
        clear_model();
        #2;
        chk_all_zero("reset");
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;

        // Basic step without damping: node 0 p(3,-2) v(0,0) -> p(3,-3) v(0,-1)
        do_load(0, 0, 3, -2, 0, 0);
        for (int n = 1; n < NN; n++)
            do_load(0, n, rnd(-60, 60), rnd(-60, 60), rnd(-10, 10), rnd(-10, 10));
        zero_forces();
        do_run(0, 0, 1'b0, 1'b0);
        chk("t1_px0", o_px0, 3);
        chk("t1_py0", o_py0, -3);
        chk("t1_vx0", o_vx0, 0);
        chk("t1_vy0", o_vy0, -1);

        // Velocity saturation and sticky flag cleared by the next run
        for (int n = 0; n < NN; n++) do_load(0, n, 0, 0, 0, 0);
        zero_forces();
        f_x[0] = 100;
        do_run(0, 0, 1'b0, 1'b0);
        chk("t2_vx0_sat", o_vx0, 31);
        chk("t2_sat_set", sat[0], 1);
        zero_forces();
        do_run(0, 0, 1'b0, 1'b0);
        chk("t2_sat_clear", sat[0], 0);

        // Backpressure for 5 cycles mid-run
        rand_forces();
        do_run(0, 2, 1'b0, 1'b0);

        // Runs on wheel 1 leave wheel 0 alone (checked by a later wheel 0 run)
        for (int n = 0; n < NN; n++)
            do_load(0, n, rnd(-100, 100), rnd(-100, 100), rnd(-20, 20), rnd(-20, 20));
        rand_forces();
        do_run(1, 1, 1'b0, 1'b0);
        rand_forces();
        do_run(1, 1, 1'b0, 1'b0);
        zero_forces();
        do_run(0, 0, 1'b0, 1'b0);

        // begin/load while running are ignored
        rand_forces();
        do_run(1, 0, 1'b0, 1'b1);

        // load in the start cycle: run uses the pre-load value
        rand_forces();
        do_run(0, 0, 1'b1, 1'b0);

        for (int i = 0; i < 6; i++) begin
            rand_forces();
            do_run(rnd(0, 1), rnd(0, 2), ($urandom_range(0, 1) == 1), 1'b0);
        end

        // Reset in the middle of a run at node 2
        @(negedge clk_in);
        begin_in = 1'b1;
        wheel_in = '0;
        @(negedge clk_in);
        begin_in = 1'b0;
        force_valid_in = 1'b1;
        node_out_ready_in = 1'b1;
        force_x_in = '0;
        force_y_in = '0;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b0;
        #1;
        chk_all_zero("midrun_reset");
        force_valid_in = 1'b0;
        @(negedge clk_in);
        rst_n_in = 1'b1;
        clear_model();
        zero_forces();
        do_run(1, 0, 1'b0, 1'b0);
        chk("t6_px0", o_px0, 0);
        chk("t6_py0", o_py0, GRAV * TDT * TDT);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
